// File: rtl/key_led_pkg.sv
// Shared types and helpers for the key-driven LED controller.
// Mode encoding, per-mode LED entry values and the per-step LED update live here.
`timescale 1ns/1ps
package key_led_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_FLOW  = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  localparam logic [3:0] LED_ENTRY_IDLE  = 4'b0000;
  localparam logic [3:0] LED_ENTRY_FLOW  = 4'b0001;
  localparam logic [3:0] LED_ENTRY_BLINK = 4'b1111;
  localparam logic [3:0] LED_ENTRY_COUNT = 4'b0000;

  localparam int NUM_SPEED = 4;

  function automatic mode_e mode_next(input mode_e cur);
    mode_e nxt;
    case (cur)
      MODE_IDLE:  nxt = MODE_FLOW;
      MODE_FLOW:  nxt = MODE_BLINK;
      MODE_BLINK: nxt = MODE_COUNT;
      MODE_COUNT: nxt = MODE_IDLE;
      default:    nxt = MODE_IDLE;
    endcase
    return nxt;
  endfunction

  function automatic logic [3:0] led_entry(input mode_e m);
    logic [3:0] val;
    case (m)
      MODE_IDLE:  val = LED_ENTRY_IDLE;
      MODE_FLOW:  val = LED_ENTRY_FLOW;
      MODE_BLINK: val = LED_ENTRY_BLINK;
      MODE_COUNT: val = LED_ENTRY_COUNT;
      default:    val = LED_ENTRY_IDLE;
    endcase
    return val;
  endfunction

  // One animation step: rotate, invert or count depending on the mode.
  function automatic logic [3:0] led_advance(input mode_e m, input logic [3:0] cur);
    logic [3:0] val;
    case (m)
      MODE_IDLE:  val = 4'b0000;
      MODE_FLOW:  val = {cur[2:0], cur[3]};
      MODE_BLINK: val = ~cur;
      MODE_COUNT: val = cur + 4'd1;
      default:    val = 4'b0000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key synchroniser, debouncer and press (falling-edge) detector.
// The press pulse is registered from the stable level, so it lands DEBOUNCE_CNT+3 edges after the key falls.
`timescale 1ns/1ps
module key_debounce
  import key_led_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q, stable_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Accept a new level only after it has differed from the stable level for DEBOUNCE_CNT cycles.
  always_comb begin
    sync1_d      = key_in;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    cnt_d        = cnt_q;
    stable_dly_d = stable_q;
    press_d      = stable_dly_q & ~stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers; released (1) is the reset level for every key stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
    end
  end

  assign press_pulse = press_q;

endmodule

// File: rtl/key_led_ctrl.sv
// Two-key LED bank controller: key0 steps the display mode, key1 steps the animation speed.
// Events are serialised (key0 first, key1 deferred one cycle) and drive a per-speed step timer.
`timescale 1ns/1ps
module key_led_ctrl
  import key_led_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 1_000_000,
  parameter int STEP_CNT     = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in0,
  input  logic       key_in1,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic [1:0] speed
);

  localparam int STEP_W = $clog2(STEP_CNT);
  localparam logic [1:0] SPEED_MAX = 2'(NUM_SPEED - 1);

  logic press0;
  logic press1;

  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_deb0 (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in0),
    .press_pulse (press0)
  );

  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_deb1 (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in1),
    .press_pulse (press1)
  );

  mode_e             mode_q, mode_d;
  logic [1:0]        speed_q, speed_d;
  logic [3:0]        led_q, led_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              pend_q, pend_d;
  logic [STEP_W-1:0] step_limit;
  logic              apply_mode;
  logic              apply_speed;

  // Scheduler plus mode/speed/LED update; an applied event always wins over a timer step.
  always_comb begin
    step_limit  = STEP_W'((STEP_CNT >> speed_q) - 1);
    apply_mode  = press0;
    apply_speed = ~press0 & (press1 | pend_q);
    pend_d      = press0 & (press1 | pend_q);
    mode_d      = mode_q;
    speed_d     = speed_q;
    led_d       = led_q;
    step_d      = step_q;
    if (apply_mode) begin
      mode_d = mode_next(mode_q);
      led_d  = led_entry(mode_next(mode_q));
      step_d = '0;
    end else if (apply_speed) begin
      if (speed_q == SPEED_MAX) begin
        speed_d = 2'd0;
      end else begin
        speed_d = speed_q + 2'd1;
      end
      step_d = '0;
    end else if (step_q == step_limit) begin
      step_d = '0;
      led_d  = led_advance(mode_q, led_q);
    end else begin
      step_d = step_q + STEP_W'(1);
    end
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_IDLE;
      speed_q <= 2'd0;
      led_q   <= LED_ENTRY_IDLE;
      step_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      speed_q <= speed_d;
      led_q   <= led_d;
      step_q  <= step_d;
      pend_q  <= pend_d;
    end
  end

  assign led   = led_q;
  assign mode  = mode_q;
  assign speed = speed_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Scoreboard bench for key_led_ctrl: expectations are queued with a target cycle while stimulus is
// driven, and popped and compared on the falling edge of that cycle.
`timescale 1ns/1ps
module tb_key_led_ctrl;

  localparam int D = 16;
  localparam int S = 32;
  localparam int F_LED   = 0;
  localparam int F_MODE  = 1;
  localparam int F_SPEED = 2;
  localparam int F_PRESS = 3;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       key_in0 = 1'b1;
  logic       key_in1 = 1'b1;
  logic [3:0] led;
  logic [1:0] mode;
  logic [1:0] speed;

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int         cyc;
    int         fld;
    logic [3:0] val;
    string      tag;
  } sb_t;

  sb_t sb[$];

  key_led_ctrl #(.DEBOUNCE_CNT(D), .STEP_CNT(S)) dut (
    .clk     (clk),
    .rst     (rst),
    .key_in0 (key_in0),
    .key_in1 (key_in1),
    .led     (led),
    .mode    (mode),
    .speed   (speed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp_v);
  endtask

  task automatic expect_at(input int c, input int fld, input logic [3:0] v, input string tag);
    sb_t e;
    int  i;
    e.cyc = c;
    e.fld = fld;
    e.val = v;
    e.tag = tag;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  function automatic logic [3:0] observe(input int fld);
    case (fld)
      F_LED:   return led;
      F_MODE:  return {2'b00, mode};
      F_SPEED: return {2'b00, speed};
      F_PRESS: return {3'b000, dut.u_deb0.press_pulse};
      default: return 4'h0;
    endcase
  endfunction

  always @(negedge clk) begin : mon
    sb_t e;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.fld), e.val);
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_key(input int which, input int at, input int hold);
    goto(at);
    if (which == 0) key_in0 = 1'b0;
    else key_in1 = 1'b0;
    goto(at + hold);
    if (which == 0) key_in0 = 1'b1;
    else key_in1 = 1'b1;
  endtask

  initial begin
    int c, f, g, h, r, k, m, n, q, s, u;

    // 1: reset state and idle hold
    expect_at(10, F_LED, 4'h0, "rst_led");
    expect_at(10, F_MODE, 4'h0, "rst_mode");
    expect_at(10, F_SPEED, 4'h0, "rst_speed");
    for (int i = 1; i <= 3; i++) begin
      expect_at(10 + 66 * i, F_LED, 4'h0, "idle_led");
      expect_at(10 + 66 * i, F_MODE, 4'h0, "idle_mode");
      expect_at(10 + 66 * i, F_SPEED, 4'h0, "idle_speed");
    end
    goto(10);
    rst = 1'b0;
    goto(210);

    // 2: bouncy key0 press, final fall at f
    c = 215;
    f = c + 7;
    expect_at(f + D + 2, F_PRESS, 4'h0, "press_early");
    expect_at(f + D + 3, F_PRESS, 4'h1, "press_on_time");
    expect_at(f + D + 4, F_PRESS, 4'h0, "press_one_cycle");
    expect_at(f + D + 3, F_MODE, 4'h0, "mode_before_evt");
    expect_at(f + 20, F_MODE, 4'h1, "mode_flow");
    expect_at(f + 20, F_LED, 4'h1, "flow_entry");
    expect_at(f + 51, F_LED, 4'h1, "flow_hold");
    expect_at(f + 52, F_LED, 4'h2, "flow_rot1");
    expect_at(f + 84, F_LED, 4'h4, "flow_rot2");
    expect_at(f + 84, F_MODE, 4'h1, "single_event");
    goto(c);
    key_in0 = 1'b0;
    goto(c + 2);
    key_in0 = 1'b1;
    goto(c + 3);
    key_in0 = 1'b0;
    goto(c + 5);
    key_in0 = 1'b1;
    goto(c + 7);
    key_in0 = 1'b0;
    goto(c + 40);
    key_in0 = 1'b1;

    // 3: short key0 press is rejected
    g = f + 90;
    expect_at(g + 40, F_MODE, 4'h1, "short_no_mode");
    expect_at(f + 115, F_LED, 4'h4, "short_led_a");
    expect_at(f + 116, F_LED, 4'h8, "short_led_b");
    expect_at(f + 147, F_LED, 4'h8, "short_led_c");
    expect_at(f + 148, F_LED, 4'h1, "short_led_d");
    press_key(0, g, 10);

    // 4: key1 steps speed 0->1->2->3->0
    h = f + 150;
    expect_at(h + 19, F_SPEED, 4'h0, "spd0_hold");
    expect_at(h + 20, F_SPEED, 4'h1, "spd1");
    expect_at(h + 70, F_SPEED, 4'h2, "spd2");
    expect_at(h + 119, F_SPEED, 4'h2, "spd2_hold");
    expect_at(h + 120, F_SPEED, 4'h3, "spd3");
    expect_at(h + 120, F_LED, 4'h2, "spd3_led0");
    expect_at(h + 123, F_LED, 4'h2, "spd3_led1");
    expect_at(h + 124, F_LED, 4'h4, "spd3_led2");
    expect_at(h + 127, F_LED, 4'h4, "spd3_led3");
    expect_at(h + 128, F_LED, 4'h8, "spd3_led4");
    expect_at(h + 169, F_SPEED, 4'h3, "spd3_hold");
    expect_at(h + 170, F_SPEED, 4'h0, "spd_wrap");
    expect_at(h + 170, F_LED, 4'h2, "wrap_led0");
    expect_at(h + 201, F_LED, 4'h2, "wrap_led1");
    expect_at(h + 202, F_LED, 4'h4, "wrap_led2");
    for (int i = 0; i < 4; i++) press_key(1, h + 50 * i, 25);

    // 5: reset mid-animation, then both keys fall together in IDLE
    r = h + 210;
    k = r + 10;
    expect_at(r + 3, F_LED, 4'h0, "rst2_led");
    expect_at(r + 3, F_MODE, 4'h0, "rst2_mode");
    expect_at(r + 3, F_SPEED, 4'h0, "rst2_speed");
    expect_at(k + 19, F_MODE, 4'h0, "both_mode_pre");
    expect_at(k + 20, F_MODE, 4'h1, "both_mode");
    expect_at(k + 20, F_SPEED, 4'h0, "both_spd_defer");
    expect_at(k + 21, F_SPEED, 4'h1, "both_spd");
    expect_at(k + 45, F_SPEED, 4'h1, "both_spd_once");
    expect_at(k + 20, F_LED, 4'h1, "both_led");
    expect_at(k + 36, F_LED, 4'h1, "both_led_hold");
    expect_at(k + 37, F_LED, 4'h2, "both_led_step");
    goto(r);
    rst = 1'b1;
    goto(r + 3);
    rst = 1'b0;
    goto(k);
    key_in0 = 1'b0;
    key_in1 = 1'b0;
    goto(k + 25);
    key_in0 = 1'b1;
    key_in1 = 1'b1;

    // BLINK and COUNT behaviour, event colliding with a step
    m = k + 60;
    n = m + 60;
    q = n + 90;
    expect_at(m + 20, F_MODE, 4'h2, "blink_mode");
    expect_at(m + 20, F_LED, 4'hF, "blink_entry");
    expect_at(m + 35, F_LED, 4'hF, "blink_hold");
    expect_at(m + 36, F_LED, 4'h0, "blink_inv1");
    expect_at(m + 52, F_LED, 4'hF, "blink_inv2");
    expect_at(n + 20, F_MODE, 4'h3, "count_mode");
    expect_at(n + 20, F_LED, 4'h0, "count_entry");
    expect_at(n + 36, F_LED, 4'h1, "count_inc1");
    expect_at(n + 51, F_SPEED, 4'h1, "collide_spd_pre");
    expect_at(n + 52, F_SPEED, 4'h2, "collide_spd");
    expect_at(n + 52, F_LED, 4'h1, "collide_drop");
    expect_at(n + 59, F_LED, 4'h1, "collide_hold");
    expect_at(n + 60, F_LED, 4'h2, "collide_inc");
    expect_at(n + 68, F_LED, 4'h3, "count_inc3");
    expect_at(q + 20, F_MODE, 4'h0, "idle_again");
    expect_at(q + 20, F_LED, 4'h0, "idle_again_led");
    expect_at(q + 20, F_SPEED, 4'h2, "idle_again_spd");
    expect_at(q + 80, F_MODE, 4'h1, "flow_again");
    expect_at(q + 80, F_LED, 4'h1, "flow_again_led");
    expect_at(q + 140, F_MODE, 4'h2, "blink_again");
    expect_at(q + 140, F_LED, 4'hF, "blink_again_led");
    expect_at(q + 148, F_LED, 4'h0, "blink_again_inv");
    press_key(0, m, 25);
    press_key(0, n, 25);
    press_key(1, n + 32, 25);
    press_key(0, q, 25);
    press_key(0, q + 60, 25);
    press_key(0, q + 120, 25);

    // 6: reset mid-press, key still low after reset releases
    s = q + 170;
    u = s + 11;
    expect_at(u, F_LED, 4'h0, "rst3_led");
    expect_at(u, F_MODE, 4'h0, "rst3_mode");
    expect_at(u, F_SPEED, 4'h0, "rst3_speed");
    expect_at(u + 12, F_MODE, 4'h0, "rst3_no_stale");
    expect_at(u + D + 2, F_PRESS, 4'h0, "rst3_press_early");
    expect_at(u + D + 3, F_PRESS, 4'h1, "rst3_press");
    expect_at(u + D + 4, F_PRESS, 4'h0, "rst3_press_off");
    expect_at(u + D + 3, F_MODE, 4'h0, "rst3_mode_pre");
    expect_at(u + D + 4, F_MODE, 4'h1, "rst3_mode_evt");
    expect_at(u + D + 4, F_LED, 4'h1, "rst3_led_evt");
    goto(s);
    key_in0 = 1'b0;
    goto(s + 8);
    rst = 1'b1;
    goto(u);
    rst = 1'b0;
    goto(u + 30);
    key_in0 = 1'b1;
    goto(u + 60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
